// File: rtl/bist_pkg.sv
// Shared definitions for the multiplier BIST controller and its MISR.
// Contents: FSM state enum, LFSR/MISR tap masks, operand/result widths and
// the shift-with-feedback helper used by both the LFSR and the MISR.
package bist_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned RES_W = 8;

  // Tap masks select bits 7, 5, 4 and 3 for the feedback XOR.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] MISR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Shift left by one, new LSB is the XOR of the tapped bits.
  function automatic logic [7:0] shift_fb8(input logic [7:0] v, input logic [7:0] taps);
    return {v[6:0], ^(v & taps)};
  endfunction

endpackage

// File: rtl/bist_misr8.sv
// 8-bit multiple-input signature register, shared by BIST controllers.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   clr            - synchronous clear to 0 (has priority over en)
//   en             - fold d into the signature this cycle
//   d              - response word to compact
//   sig            - registered signature
//   sig_next_c     - combinational value sig will take on the next edge
module bist_misr8
  import bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [RES_W-1:0] d,
  output logic [RES_W-1:0] sig,
  output logic [RES_W-1:0] sig_next_c
);

  logic [RES_W-1:0] sig_q;
  logic [RES_W-1:0] sig_d;

  // Next signature: clear, compact, or hold.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = shift_fb8(sig_q, MISR_TAPS) ^ d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig        = sig_q;
  assign sig_next_c = sig_d;

endmodule

// File: rtl/bist_mult_ctrl.sv
// BIST controller for the 4x4 Booth multiplier: drives LFSR patterns onto the
// multiplier operands, compacts the registered products in a MISR and compares
// the final signature against GOLDEN_SIG.
// Optional feature macro: BIST_FUNC_MUX_EN adds func_a/func_b, which are
// forwarded (registered) to the multiplier while the BIST is idle or done.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   start            - run request, honoured in IDLE or DONE only
//   mul_result       - registered product from the multiplier
//   func_a, func_b   - functional operands (BIST_FUNC_MUX_EN only)
//   mul_a, mul_b     - multiplier operands (registered)
//   busy             - high in RUN and FLUSH
//   done             - high in DONE
//   pass             - signature matched GOLDEN_SIG (valid with done)
//   signature        - MISR contents
module bist_mult_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 255,
  parameter logic [7:0]  LFSR_SEED    = 8'h01,
  parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RES_W-1:0] mul_result,
`ifdef BIST_FUNC_MUX_EN
  input  logic [OP_W-1:0]  func_a,
  input  logic [OP_W-1:0]  func_b,
`endif
  output logic [OP_W-1:0]  mul_a,
  output logic [OP_W-1:0]  mul_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [RES_W-1:0] signature
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  bist_state_e         state_q, state_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [2*OP_W-1:0]   ops_q, ops_d;
  logic                misr_clr;
  logic                misr_en;
  logic [RES_W-1:0]    misr_sig;
  logic [RES_W-1:0]    misr_next_c;

  // FSM, LFSR, pattern counter and pass flag.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          lfsr_d   = LFSR_SEED;
          cnt_d    = '0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
        end
      end
      ST_RUN: begin
        lfsr_d  = shift_fb8(lfsr_q, LFSR_TAPS);
        cnt_d   = cnt_q + CNT_W'(1);
        // First RUN cycle sees no product yet (one-cycle multiplier latency).
        misr_en = (cnt_q != '0);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        misr_en = 1'b1;
        state_d = ST_DONE;
        pass_d  = (misr_next_c == GOLDEN_SIG);
      end
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
`ifdef BIST_FUNC_MUX_EN
    if ((state_d == ST_RUN) || (state_d == ST_FLUSH)) begin
      ops_d = lfsr_d;
    end else begin
      ops_d = {func_a, func_b};
    end
`else
    ops_d = (state_d == ST_RUN) ? lfsr_d : '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ops_q   <= ops_d;
    end
  end

  bist_misr8 u_misr (
    .clk        (clk),
    .rst        (rst),
    .clr        (misr_clr),
    .en         (misr_en),
    .d          (mul_result),
    .sig        (misr_sig),
    .sig_next_c (misr_next_c)
  );

  assign mul_a     = ops_q[2*OP_W-1:OP_W];
  assign mul_b     = ops_q[OP_W-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_sig;

endmodule

// File: tb/tb_bist_mult_ctrl.sv
// Self-checking bench for bist_mult_ctrl: a 4-pattern and a 255-pattern
// instance, each feeding a registered signed-multiplier model with optional
// fault masks; expectations come from a pattern-list reference model.
`timescale 1ns/1ps
module tb_bist_mult_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst4, start4, busy4, done4, pass4;
  logic [7:0] res4, sig4, or4, xor4;
  logic [3:0] a4, b4;
  logic       rst255, start255, busy255, done255, pass255;
  logic [7:0] res255, sig255, xor255;
  logic [3:0] a255, b255;
`ifdef BIST_FUNC_MUX_EN
  logic [3:0] fa4, fb4, fa255, fb255;
`endif

  bist_mult_ctrl #(.NUM_PATTERNS(4), .LFSR_SEED(8'h01), .GOLDEN_SIG(8'h00)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .mul_result(res4),
`ifdef BIST_FUNC_MUX_EN
    .func_a(fa4), .func_b(fb4),
`endif
    .mul_a(a4), .mul_b(b4), .busy(busy4), .done(done4), .pass(pass4), .signature(sig4)
  );

  bist_mult_ctrl #(.NUM_PATTERNS(255), .LFSR_SEED(8'h5A), .GOLDEN_SIG(8'h00)) u_dut255 (
    .clk(clk), .rst(rst255), .start(start255), .mul_result(res255),
`ifdef BIST_FUNC_MUX_EN
    .func_a(fa255), .func_b(fb255),
`endif
    .mul_a(a255), .mul_b(b255), .busy(busy255), .done(done255), .pass(pass255), .signature(sig255)
  );

  // Signed 4x4 product, exact in 8 bits.
  function automatic logic [7:0] mult(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] sa, sb, p;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    p  = sa * sb;
    return p;
  endfunction

  // Multiplier stand-ins with one-cycle latency and fault masks.
  always @(posedge clk) begin
    res4   <= (mult(a4, b4) | or4) ^ xor4;
    res255 <= mult(a255, b255) ^ xor255;
  end

  function automatic logic [7:0] step8(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference: enumerate the n patterns, form each response, fold into signature.
  function automatic logic [7:0] exp_sig(input logic [7:0] seed, input int n,
                                         input logic [7:0] orm, input logic [7:0] xorm);
    logic [7:0] pat, sig;
    pat = seed;
    sig = 8'h00;
    for (int i = 0; i < n; i++) begin
      sig = step8(sig) ^ ((mult(pat[7:4], pat[3:0]) | orm) ^ xorm);
      pat = step8(pat);
    end
    return sig;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start edge = cycle 0; returns positioned in cycle 1.
  task automatic pulse4;
    @(negedge clk) start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
  endtask

  task automatic pulse255;
    @(negedge clk) start255 = 1'b1;
    @(posedge clk);
    #1 start255 = 1'b0;
  endtask

  // From cycle 1, wait (bounded) for done on the 4-pattern DUT; optional start pokes.
  task automatic wait4(input bit poke, output int busy_n, output int done_at);
    busy_n  = 0;
    done_at = -1;
    for (int c = 1; c <= 20; c++) begin
      if (busy4) busy_n++;
      if (done4) begin
        done_at = c;
        break;
      end
      start4 = (poke && busy4) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    start4 = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({a4, b4, busy4, done4, pass4, sig4} !== 19'd0) begin
      errors++; $display("FAIL reset_out4 got=%h exp=%h", {a4, b4, busy4, done4, pass4, sig4}, 19'd0);
    end
    checks++;
    if ({a255, b255, busy255, done255, pass255, sig255} !== 19'd0) begin
      errors++; $display("FAIL reset_out255 got=%h exp=%h", {a255, b255, busy255, done255, pass255, sig255}, 19'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) begin rst4 = 1'b0; rst255 = 1'b0; end
    repeat (3) tick();
    checks++;
    if ({a4, b4, busy4, done4, pass4, sig4} !== 19'd0) begin
      errors++; $display("FAIL reset_release4 got=%h exp=%h", {a4, b4, busy4, done4, pass4, sig4}, 19'd0);
    end
    checks++;
    if ({a255, b255, busy255, done255, pass255, sig255} !== 19'd0) begin
      errors++; $display("FAIL reset_release255 got=%h exp=%h", {a255, b255, busy255, done255, pass255, sig255}, 19'd0);
    end
  endtask

  task automatic test_golden;
    logic [7:0] pat;
    logic [7:0] ev;
    pat = 8'h01;
    pulse4();
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        checks++;
        if ({a4, b4} !== pat) begin
          errors++; $display("FAIL golden_ops c=%0d got=%h exp=%h", c, {a4, b4}, pat);
        end
        pat = step8(pat);
      end
      checks++;
      if (busy4 !== (c <= 5)) begin
        errors++; $display("FAIL golden_busy c=%0d got=%b exp=%b", c, busy4, (c <= 5));
      end
      checks++;
      if (done4 !== (c == 6)) begin
        errors++; $display("FAIL golden_done c=%0d got=%b exp=%b", c, done4, (c == 6));
      end
      if (c < 6) tick();
    end
    ev = exp_sig(8'h01, 4, 8'h00, 8'h00);
    checks++;
    if (sig4 !== ev) begin
      errors++; $display("FAIL golden_sig got=%h exp=%h", sig4, ev);
    end
    checks++;
    if (pass4 !== 1'b1) begin
      errors++; $display("FAIL golden_pass got=%b exp=1", pass4);
    end
    checks++;
    if ({a4, b4} !== 8'h00) begin
      errors++; $display("FAIL golden_done_ops got=%h exp=00", {a4, b4});
    end
  endtask

  task automatic test_stuck_at;
    int bn, da;
    or4 = 8'h01;
    pulse4();
    wait4(1'b0, bn, da);
    checks++;
    if (da !== 6) begin
      errors++; $display("FAIL stuck_latency got=%0d exp=6", da);
    end
    checks++;
    if (sig4 !== 8'h0F) begin
      errors++; $display("FAIL stuck_sig got=%h exp=0f", sig4);
    end
    checks++;
    if (pass4 !== 1'b0) begin
      errors++; $display("FAIL stuck_pass got=%b exp=0", pass4);
    end
    or4 = 8'h00;
  endtask

  task automatic test_restart;
    int bn, da;
    logic [7:0] ev;
    ev = exp_sig(8'h01, 4, 8'h00, 8'h00);
    pulse4();
    wait4(1'b1, bn, da);
    checks++;
    if (bn !== 5 || da !== 6) begin
      errors++; $display("FAIL restart_poke_timing busy=%0d done_at=%0d exp=5/6", bn, da);
    end
    checks++;
    if (pass4 !== 1'b1 || sig4 !== ev) begin
      errors++; $display("FAIL restart_first pass=%b sig=%h exp=1/%h", pass4, sig4, ev);
    end
    pulse4();
    checks++;
    if ({pass4, done4, busy4, sig4} !== {3'b001, 8'h00}) begin
      errors++; $display("FAIL restart_start_edge got=%h exp=%h", {pass4, done4, busy4, sig4}, {3'b001, 8'h00});
    end
    wait4(1'b0, bn, da);
    checks++;
    if (bn !== 5 || da !== 6) begin
      errors++; $display("FAIL restart_second_timing busy=%0d done_at=%0d exp=5/6", bn, da);
    end
    checks++;
    if (pass4 !== 1'b1 || sig4 !== ev) begin
      errors++; $display("FAIL restart_second pass=%b sig=%h exp=1/%h", pass4, sig4, ev);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk) start4 = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if ({done4, busy4} !== {(c % 6 == 0), (c % 6 != 0)}) begin
        errors++; $display("FAIL b2b c=%0d done_busy got=%b%b exp=%b%b", c, done4, busy4, (c % 6 == 0), (c % 6 != 0));
      end
      if (c < 12) tick();
    end
    start4 = 1'b0;
    tick();
    checks++;
    if (done4 !== 1'b1 || sig4 !== exp_sig(8'h01, 4, 8'h00, 8'h00)) begin
      errors++; $display("FAIL b2b_hold done=%b sig=%h exp=1/%h", done4, sig4, exp_sig(8'h01, 4, 8'h00, 8'h00));
    end
  endtask

  task automatic test_random;
    logic [7:0] pat;
    logic [7:0] ev;
    for (int r = 0; r < 3; r++) begin
      xor255 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      repeat ($urandom_range(0, 5)) tick();
      pulse255();
      pat = 8'h5A;
      for (int c = 1; c <= 257; c++) begin
        if (c <= 255) begin
          checks++;
          if ({a255, b255} !== pat) begin
            errors++; $display("FAIL rand_ops r=%0d c=%0d got=%h exp=%h", r, c, {a255, b255}, pat);
          end
          pat = step8(pat);
        end
        checks++;
        if ({busy255, done255} !== {(c <= 256), (c == 257)}) begin
          errors++; $display("FAIL rand_status r=%0d c=%0d got=%b%b exp=%b%b", r, c, busy255, done255, (c <= 256), (c == 257));
        end
        if (c < 257) begin
          start255 = ($urandom_range(0, 15) == 0);
          tick();
        end
      end
      start255 = 1'b0;
      ev = exp_sig(8'h5A, 255, 8'h00, xor255);
      checks++;
      if (sig255 !== ev) begin
        errors++; $display("FAIL rand_sig r=%0d xor=%h got=%h exp=%h", r, xor255, sig255, ev);
      end
      checks++;
      if (pass255 !== (ev == 8'h00)) begin
        errors++; $display("FAIL rand_pass r=%0d got=%b exp=%b", r, pass255, (ev == 8'h00));
      end
    end
    xor255 = 8'h00;
  endtask

  task automatic test_reset_midrun;
    logic [7:0] ev;
    int da;
    pulse255();
    tick();
    tick();
    checks++;
    if (busy255 !== 1'b1) begin
      errors++; $display("FAIL midrun_busy_before got=%b exp=1", busy255);
    end
    #2 rst255 = 1'b1;
    #1;
    checks++;
    if ({a255, b255, busy255, done255, pass255, sig255} !== 19'd0) begin
      errors++; $display("FAIL midrun_reset got=%h exp=%h", {a255, b255, busy255, done255, pass255, sig255}, 19'd0);
    end
    @(negedge clk) rst255 = 1'b0;
    tick();
    checks++;
    if ({busy255, done255, sig255} !== 10'd0) begin
      errors++; $display("FAIL midrun_idle got=%h exp=000", {busy255, done255, sig255});
    end
    pulse255();
    da = -1;
    for (int c = 1; c <= 300; c++) begin
      if (done255) begin
        da = c;
        break;
      end
      tick();
    end
    ev = exp_sig(8'h5A, 255, 8'h00, 8'h00);
    checks++;
    if (da !== 257) begin
      errors++; $display("FAIL midrun_rerun_latency got=%0d exp=257", da);
    end
    checks++;
    if (sig255 !== ev || pass255 !== (ev == 8'h00)) begin
      errors++; $display("FAIL midrun_rerun sig=%h pass=%b exp=%h/%b", sig255, pass255, ev, (ev == 8'h00));
    end
  endtask

`ifdef BIST_FUNC_MUX_EN
  task automatic test_func_mux;
    logic [7:0] pat;
    @(negedge clk) begin fa4 = 4'h3; fb4 = 4'h5; end
    @(posedge clk);
    #1;
    checks++;
    if ({a4, b4} !== 8'h35) begin
      errors++; $display("FAIL mux_idle got=%h exp=35", {a4, b4});
    end
    pulse4();
    pat = 8'h01;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if ({a4, b4} !== pat) begin
        errors++; $display("FAIL mux_run c=%0d got=%h exp=%h", c, {a4, b4}, pat);
      end
      pat = step8(pat);
      tick();
    end
    checks++;
    if ({done4, a4, b4} !== {1'b1, 8'h35}) begin
      errors++; $display("FAIL mux_done got=%h exp=%h", {done4, a4, b4}, {1'b1, 8'h35});
    end
  endtask
`endif

  initial begin
    rst4 = 1'b1; rst255 = 1'b1;
    start4 = 1'b0; start255 = 1'b0;
    or4 = 8'h00; xor4 = 8'h00; xor255 = 8'h00;
`ifdef BIST_FUNC_MUX_EN
    fa4 = 4'h0; fb4 = 4'h0; fa255 = 4'h0; fb255 = 4'h0;
`endif
    test_reset();
    test_golden();
    test_stuck_at();
    test_restart();
    test_back_to_back();
    test_random();
    test_reset_midrun();
`ifdef BIST_FUNC_MUX_EN
    test_func_mux();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
